zion_bin2oh_pipe: RTL and testbench
===================================

# zion_bin2oh_pipe

Multi-channel, pipelined binary-to-one-hot decoder with a valid/ready handshake. Each channel maps a binary code to a one-hot vector whose bit i is set when the code equals START + i*STEP, and flags codes that hit no bit. A two-entry skid buffer gives a registered output and full throughput under backpressure. It sits between index-producing logic (arbiters, address decoders) and one-hot consumers that may stall.

## Interface
- CH, 4, number of independent decode channels
- WIDTH_IN, 5, bits per input code
- WIDTH_OUT, 32, one-hot bits per channel
- START, 0, code mapped to output bit 0
- STEP, 1, code increment per output bit; must be >= 1
- ERR_CNT_W, 16, width of the out-of-range event counter

- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous reset, active-low
- i_vld  input  1  input beat valid
- o_rdy  output  1  block can accept an input beat
- i_dat  input  CH*WIDTH_IN  channel c code in bits [c*WIDTH_IN +: WIDTH_IN]
- o_vld  output  1  output beat valid
- i_rdy  input  1  downstream accepts output beat
- o_dat  output  CH*WIDTH_OUT  channel c one-hot in bits [c*WIDTH_OUT +: WIDTH_OUT]
- o_oor  output  CH  channel c code matched no output bit
- o_err_cnt  output  ERR_CNT_W  saturating out-of-range count (only with ZION_BIN2OH_ERRCNT_EN)

## Operation
- Decode per channel: o_dat bit i = (code == START + i*STEP), i in 0..WIDTH_OUT-1; o_oor = no bit set.
- Targets START + i*STEP evaluated as 32-bit unsigned constants; targets above 2^WIDTH_IN-1 never match. Code compared zero-extended to 32 bits.
- Input handshake: beat accepted when i_vld && o_rdy. Output handshake: beat retired when o_vld && i_rdy.
- Storage: output register (OUT) and skid register (SKID); state machine states EMPTY, ONE, FULL.
  - EMPTY: accept -> decode into OUT, go ONE.
  - ONE: accept and retire -> OUT reloaded, stay ONE; accept only -> decode into SKID, go FULL; retire only -> EMPTY.
  - FULL: retire -> SKID moves to OUT, go ONE; no accept possible.
- o_rdy = (state != FULL); o_vld = (state != EMPTY). o_rdy depends only on state, never combinationally on i_rdy.
- o_dat/o_oor driven straight from OUT; held stable while o_vld && !i_rdy.
- Beats delivered in acceptance order; none dropped or duplicated.
- i_dat ignored when i_vld low or o_rdy low.

## Timing
- Reset (rst_n low, asynchronous): state EMPTY, o_vld 0, o_rdy 1, o_dat all 0, o_oor all 0, o_err_cnt 0.
- Latency: beat accepted in cycle n is on output in cycle n+1.
- Throughput: one beat per cycle when i_rdy held high.
- Backpressure: with i_rdy low, two beats accepted, then o_rdy low from the next cycle.
- Reset mid-operation discards OUT and SKID contents immediately; no beat is emitted after reset release until a new accept.
- First accept possible in the first clock edge after rst_n deasserts.

## Configuration
- ZION_BIN2OH_ERRCNT_EN defined: o_err_cnt present. It increments by 1 on every accepted input beat in which at least one channel is out of range. It saturates at all-ones and resets to 0.
- Undefined: o_err_cnt port and counter absent. All other behaviour is identical.

## Structure
- Package zion_bin2oh_pkg: state enum (EMPTY, ONE, FULL) and a function computing the 32-bit target for index i from START/STEP.
- Sub-module zion_bin2oh_dec: combinational single-channel decoder (code -> one-hot + oor), instantiated CH times. Registers and FSM stay in the top.

## Test plan
- Defaults, i_rdy=1, channel codes {0,5,31,17} -> next cycle o_dat channels = 1<<0, 1<<5, 1<<31, 1<<17; o_oor=4'b0000.
- START=3, STEP=2, WIDTH_OUT=8, code 7 -> bit 2 set; code 4 -> zero vector, o_oor bit set; code 19 (target 17 max) -> o_oor set.
- i_rdy=0, three consecutive i_vld beats A,B,C -> A,B accepted, o_rdy=0 from cycle 2, C held. i_rdy=1 -> outputs A,B,C in order, one per cycle.
- Random i_vld/i_rdy over 1000 beats -> output stream equals the model-decoded input stream; o_dat stable whenever o_vld && !i_rdy.
- rst_n pulsed low while FULL -> o_vld=0, o_rdy=1, o_dat=0 asynchronously; the next beat after release appears alone.
- With ZION_BIN2OH_ERRCNT_EN and ERR_CNT_W=2: five beats each with one oor channel -> o_err_cnt 1,2,3,3,3; beats with no oor leave it unchanged.

Source files
------------

// File: rtl/zion_bin2oh_pkg.sv
// Shared types and helpers for the zion_bin2oh_pipe decoder.
// State encoding and the per-bit target-code calculation.
package zion_bin2oh_pkg;

    localparam int unsigned TGT_W = 32;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    // Code that lights output bit idx; wraps modulo 2^32 like the constants it models.
    function automatic logic [TGT_W-1:0] bin2oh_target(input int unsigned start,
                                                       input int unsigned step,
                                                       input int unsigned idx);
        return TGT_W'(start) + TGT_W'(idx) * TGT_W'(step);
    endfunction

endpackage

// File: rtl/zion_bin2oh_dec.sv
// Combinational single-channel binary-to-one-hot decoder with out-of-range flag.
module zion_bin2oh_dec
    import zion_bin2oh_pkg::*;
#(
    parameter int unsigned WIDTH_IN  = 5,
    parameter int unsigned WIDTH_OUT = 32,
    parameter int unsigned START     = 0,
    parameter int unsigned STEP      = 1
) (
    input  logic [WIDTH_IN-1:0]  code_i,
    output logic [WIDTH_OUT-1:0] onehot_c,
    output logic                 oor_c
);

    logic [TGT_W-1:0] code_ext;

    assign code_ext = TGT_W'(code_i);

    // Targets beyond the code range can never equal the zero-extended code.
    always_comb begin
        onehot_c = '0;
        for (int unsigned i = 0; i < WIDTH_OUT; i++) begin
            onehot_c[i] = (code_ext == bin2oh_target(START, STEP, i));
        end
    end

    assign oor_c = ~|onehot_c;

endmodule

// File: rtl/zion_bin2oh_pipe.sv
// Multi-channel pipelined binary-to-one-hot decoder behind a two-entry skid buffer.
// Define ZION_BIN2OH_ERRCNT_EN to add the saturating out-of-range counter o_err_cnt.
module zion_bin2oh_pipe
    import zion_bin2oh_pkg::*;
#(
    parameter int unsigned CH        = 4,
    parameter int unsigned WIDTH_IN  = 5,
    parameter int unsigned WIDTH_OUT = 32,
    parameter int unsigned START     = 0,
    parameter int unsigned STEP      = 1,
    parameter int unsigned ERR_CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_vld,
    output logic                    o_rdy,
    input  logic [CH*WIDTH_IN-1:0]  i_dat,
    output logic                    o_vld,
    input  logic                    i_rdy,
    output logic [CH*WIDTH_OUT-1:0] o_dat,
    output logic [CH-1:0]           o_oor
`ifdef ZION_BIN2OH_ERRCNT_EN
    ,
    output logic [ERR_CNT_W-1:0]    o_err_cnt
`endif
);

    if (STEP == 0) begin : g_bad_step
        $error("zion_bin2oh_pipe: STEP must be >= 1");
    end
    if (ERR_CNT_W == 0) begin : g_bad_cnt_w
        $error("zion_bin2oh_pipe: ERR_CNT_W must be >= 1");
    end

    logic [CH*WIDTH_OUT-1:0] dec_dat;
    logic [CH-1:0]           dec_oor;
    logic                    accept_c;
    logic                    retire_c;

    state_e                  state_q;
    logic                    vld_q;
    logic                    rdy_q;
    logic [CH*WIDTH_OUT-1:0] out_dat_q;
    logic [CH-1:0]           out_oor_q;
    logic [CH*WIDTH_OUT-1:0] skid_dat_q;
    logic [CH-1:0]           skid_oor_q;

    for (genvar c = 0; c < CH; c++) begin : g_ch
        zion_bin2oh_dec #(
            .WIDTH_IN  (WIDTH_IN),
            .WIDTH_OUT (WIDTH_OUT),
            .START     (START),
            .STEP      (STEP)
        ) u_dec (
            .code_i   (i_dat[c*WIDTH_IN +: WIDTH_IN]),
            .onehot_c (dec_dat[c*WIDTH_OUT +: WIDTH_OUT]),
            .oor_c    (dec_oor[c])
        );
    end

    assign accept_c = i_vld & rdy_q;
    assign retire_c = vld_q & i_rdy;

    // Skid FSM; o_vld/o_rdy are kept as flops alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            vld_q      <= 1'b0;
            rdy_q      <= 1'b1;
            out_dat_q  <= '0;
            out_oor_q  <= '0;
            skid_dat_q <= '0;
            skid_oor_q <= '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept_c) begin
                        out_dat_q <= dec_dat;
                        out_oor_q <= dec_oor;
                        vld_q     <= 1'b1;
                        state_q   <= ONE;
                    end
                end
                ONE: begin
                    if (accept_c && retire_c) begin
                        out_dat_q <= dec_dat;
                        out_oor_q <= dec_oor;
                    end else if (accept_c) begin
                        skid_dat_q <= dec_dat;
                        skid_oor_q <= dec_oor;
                        rdy_q      <= 1'b0;
                        state_q    <= FULL;
                    end else if (retire_c) begin
                        vld_q   <= 1'b0;
                        state_q <= EMPTY;
                    end
                end
                FULL: begin
                    if (retire_c) begin
                        out_dat_q <= skid_dat_q;
                        out_oor_q <= skid_oor_q;
                        rdy_q     <= 1'b1;
                        state_q   <= ONE;
                    end
                end
                default: begin
                    vld_q   <= 1'b0;
                    rdy_q   <= 1'b1;
                    state_q <= EMPTY;
                end
            endcase
        end
    end

    assign o_vld = vld_q;
    assign o_rdy = rdy_q;
    assign o_dat = out_dat_q;
    assign o_oor = out_oor_q;

`ifdef ZION_BIN2OH_ERRCNT_EN
    logic [ERR_CNT_W-1:0] err_cnt_q;

    // Counts accepted beats with any out-of-range channel, sticking at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else if (accept_c && (|dec_oor) && (err_cnt_q != '1)) begin
            err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
        end
    end

    assign o_err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_zion_bin2oh_pipe.sv
// Self-checking bench for zion_bin2oh_pipe: directed steps plus a randomized run
// checked against a capacity-two queue model with arithmetic decode.
module tb_zion_bin2oh_pipe;

    localparam int unsigned CH  = 4;
    localparam int unsigned WI  = 5;
    localparam int unsigned WO  = 32;
    localparam int unsigned WO2 = 8;
    localparam int unsigned S2  = 3;
    localparam int unsigned ST2 = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic              i_vld, i_rdy, o_vld, o_rdy;
    logic [CH*WI-1:0]  i_dat;
    logic [CH*WO-1:0]  o_dat;
    logic [CH-1:0]     o_oor;

    logic              i_vld2, i_rdy2, o_vld2, o_rdy2;
    logic [WI-1:0]     i_dat2;
    logic [WO2-1:0]    o_dat2;
    logic [0:0]        o_oor2;

`ifdef ZION_BIN2OH_ERRCNT_EN
    logic [15:0]       o_err_cnt;
    logic [1:0]        o_err_cnt2;
`endif

    int unsigned errors = 0;
    int unsigned checks = 0;

    always #5 clk = ~clk;

    zion_bin2oh_pipe #(
        .CH(CH), .WIDTH_IN(WI), .WIDTH_OUT(WO), .START(0), .STEP(1), .ERR_CNT_W(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_vld(i_vld), .o_rdy(o_rdy), .i_dat(i_dat),
        .o_vld(o_vld), .i_rdy(i_rdy), .o_dat(o_dat), .o_oor(o_oor)
`ifdef ZION_BIN2OH_ERRCNT_EN
        , .o_err_cnt(o_err_cnt)
`endif
    );

    zion_bin2oh_pipe #(
        .CH(1), .WIDTH_IN(WI), .WIDTH_OUT(WO2), .START(S2), .STEP(ST2), .ERR_CNT_W(2)
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .i_vld(i_vld2), .o_rdy(o_rdy2), .i_dat(i_dat2),
        .o_vld(o_vld2), .i_rdy(i_rdy2), .o_dat(o_dat2), .o_oor(o_oor2)
`ifdef ZION_BIN2OH_ERRCNT_EN
        , .o_err_cnt(o_err_cnt2)
`endif
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bit index is (code-start)/step when the code lands exactly on the lattice.
    function automatic logic [31:0] model_dec(input int unsigned code, input int unsigned start,
                                              input int unsigned step, input int unsigned wout);
        logic [31:0] v;
        v = '0;
        if (code >= start && ((code - start) % step) == 0 && ((code - start) / step) < wout)
            v[(code - start) / step] = 1'b1;
        return v;
    endfunction

    function automatic logic [CH*WO-1:0] exp_dat(input logic [CH*WI-1:0] d);
        logic [CH*WO-1:0] r;
        r = '0;
        for (int c = 0; c < CH; c++) r[c*WO +: WO] = model_dec(int'(d[c*WI +: WI]), 0, 1, WO);
        return r;
    endfunction

    function automatic logic [CH-1:0] exp_oor(input logic [CH*WI-1:0] d);
        logic [CH-1:0] r;
        r = '0;
        for (int c = 0; c < CH; c++) r[c] = (model_dec(int'(d[c*WI +: WI]), 0, 1, WO) == 32'd0);
        return r;
    endfunction

    initial begin
        logic [CH*WI-1:0] a, b, cc, d;
        logic [CH*WI-1:0] q[$];
        logic [CH*WO-1:0] prev_dat;
        logic [127:0]     e_vec;
        logic             prev_hold, acc, ret;
        int unsigned      accepted, cyc;
        int unsigned      c2[8]   = '{7, 4, 19, 3, 17, 0, 1, 2};
        logic [7:0]       d2[8]   = '{8'h04, 8'h00, 8'h00, 8'h01, 8'h80, 8'h00, 8'h00, 8'h00};
        logic             oor2[8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        int unsigned      cnt2[8] = '{0, 1, 2, 2, 2, 3, 3, 3};

        i_vld = 1'b0; i_rdy = 1'b1; i_dat = '0;
        i_vld2 = 1'b0; i_rdy2 = 1'b1; i_dat2 = '0;
        rst_n = 1'b0;
        tick(); tick();

        chk("rst_vld", o_vld, 1'b0);
        chk("rst_rdy", o_rdy, 1'b1);
        chk("rst_dat", o_dat, '0);
        chk("rst_oor", o_oor, '0);
`ifdef ZION_BIN2OH_ERRCNT_EN
        chk("rst_errcnt", o_err_cnt, '0);
`endif
        rst_n = 1'b1;

        // Basic decode, accepted on the first edge after release.
        i_vld = 1'b1;
        i_dat = {5'd17, 5'd31, 5'd5, 5'd0};
        tick();
        i_vld = 1'b0;
        e_vec = {32'h0002_0000, 32'h8000_0000, 32'h0000_0020, 32'h0000_0001};
        chk("basic_vld", o_vld, 1'b1);
        chk("basic_dat", o_dat, e_vec);
        chk("basic_oor", o_oor, 4'b0000);
        tick();
        chk("basic_drain", o_vld, 1'b0);

        // Sparse lattice START=3 STEP=2 WIDTH_OUT=8, back to back.
        i_vld2 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            i_dat2 = WI'(c2[k]);
            tick();
            chk($sformatf("lat_vld_%0d", c2[k]), o_vld2, 1'b1);
            chk($sformatf("lat_dat_%0d", c2[k]), o_dat2, d2[k]);
            chk($sformatf("lat_model_%0d", c2[k]), o_dat2, model_dec(c2[k], S2, ST2, WO2));
            chk($sformatf("lat_oor_%0d", c2[k]), o_oor2, oor2[k]);
`ifdef ZION_BIN2OH_ERRCNT_EN
            chk($sformatf("errcnt_%0d", k), o_err_cnt2, 2'(cnt2[k]));
`endif
        end
        i_vld2 = 1'b0;
        tick();
        chk("lat_drain", o_vld2, 1'b0);
`ifdef ZION_BIN2OH_ERRCNT_EN
        chk("errcnt_hold", o_err_cnt2, 2'd3);
`endif

        // Backpressure: A, B accepted, C held until space opens.
        a  = {5'd1, 5'd2, 5'd3, 5'd4};
        b  = {5'd9, 5'd10, 5'd11, 5'd12};
        cc = {5'd30, 5'd29, 5'd28, 5'd27};
        i_rdy = 1'b0; i_vld = 1'b1; i_dat = a;
        tick();
        chk("bp_rdy1", o_rdy, 1'b1);
        chk("bp_dat_a", o_dat, exp_dat(a));
        i_dat = b;
        tick();
        chk("bp_rdy2", o_rdy, 1'b0);
        chk("bp_hold_a1", o_dat, exp_dat(a));
        i_dat = cc;
        tick();
        chk("bp_rdy3", o_rdy, 1'b0);
        chk("bp_hold_a2", o_dat, exp_dat(a));
        i_rdy = 1'b1;
        tick();
        chk("bp_dat_b", o_dat, exp_dat(b));
        chk("bp_rdy4", o_rdy, 1'b1);
        tick();
        i_vld = 1'b0;
        chk("bp_dat_c", o_dat, exp_dat(cc));
        chk("bp_vld_c", o_vld, 1'b1);
        tick();
        chk("bp_empty", o_vld, 1'b0);

        // Asynchronous reset while FULL, then a single fresh beat.
        i_rdy = 1'b0; i_vld = 1'b1; i_dat = a;
        tick();
        i_dat = b;
        tick();
        i_vld = 1'b0;
        chk("rstfull_rdy_pre", o_rdy, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("rstfull_vld", o_vld, 1'b0);
        chk("rstfull_rdy", o_rdy, 1'b1);
        chk("rstfull_dat", o_dat, '0);
        chk("rstfull_oor", o_oor, '0);
        tick();
        rst_n = 1'b1;
        d = {5'd6, 5'd7, 5'd8, 5'd9};
        i_rdy = 1'b1; i_vld = 1'b1; i_dat = d;
        tick();
        i_vld = 1'b0;
        chk("rstfull_new_vld", o_vld, 1'b1);
        chk("rstfull_new_dat", o_dat, exp_dat(d));
        tick();
        chk("rstfull_alone", o_vld, 1'b0);

        // Random traffic against a two-deep FIFO model.
        q.delete();
        prev_hold = 1'b0;
        prev_dat  = '0;
        accepted  = 0;
        cyc       = 0;
        while (accepted < 1000 && cyc < 6000) begin
            cyc++;
            chk("rnd_vld", o_vld, q.size() != 0);
            chk("rnd_rdy", o_rdy, q.size() < 2);
            if (q.size() != 0) begin
                chk("rnd_dat", o_dat, exp_dat(q[0]));
                chk("rnd_oor", o_oor, exp_oor(q[0]));
            end
            if (prev_hold) chk("rnd_stable", o_dat, prev_dat);
            i_vld = ($urandom_range(0, 3) != 0);
            i_rdy = ($urandom_range(0, 2) != 0);
            i_dat = (CH*WI)'($urandom);
            acc = i_vld && o_rdy;
            ret = o_vld && i_rdy;
            prev_hold = o_vld && !i_rdy;
            prev_dat  = o_dat;
            tick();
            if (ret && q.size() != 0) void'(q.pop_front());
            if (acc) begin
                q.push_back(i_dat);
                accepted++;
            end
        end
        chk("rnd_budget", accepted >= 1000, 1'b1);
        i_vld = 1'b0;
        i_rdy = 1'b1;
        tick(); tick();
        chk("rnd_final_empty", o_vld, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
